// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/writeback bus of the scoreboarded register file
interface reg_file_sb_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRP   = 2,
  parameter int NDBG  = 8
);
  logic [NRP-1:0]       rd_valid;
  logic [NRP*AW-1:0]    rd_addr;
  logic [NRP*XLEN-1:0]  rd_data;
  logic [NRP-1:0]       rd_busy;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic                 flush;
  logic                 stall;
  logic [NREGS-1:0]     busy_vec;
  logic [NDBG*XLEN-1:0] dbg_data;
  modport master (
    output rd_valid, rd_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data, flush,
    input  rd_data, rd_busy, stall, busy_vec, dbg_data
  );
  modport slave (
    input  rd_valid, rd_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data, flush,
    output rd_data, rd_busy, stall, busy_vec, dbg_data
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: NRP-read/1-write register file with pending-write scoreboard and decode stall
// Optional write-through bypass: define REGFILE_BYPASS_EN
module reg_file_sb #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRP   = 2,
  parameter int NDBG  = 8
) (
  input logic          clk,
  input logic          reset,
  reg_file_sb_if.slave bus
);
  logic [XLEN-1:0]     regs [NREGS];
  logic [1:0]          cnt  [NREGS];
  logic [NREGS-1:0]    busy, wr_hit, iss_hit, inc;
  logic [NRP-1:0]      rd_busy, rd_hold;
  logic [NRP*XLEN-1:0] rd_data;
  logic                iss_full, stall;
  // per-register address decode; register 0 and out-of-range addresses never hit
  always_comb begin
    iss_full = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      wr_hit[r]  = reset && bus.wr_en && r != 0 && bus.wr_addr == AW'(r);
      iss_hit[r] = bus.iss_en && r != 0 && bus.iss_addr == AW'(r);
      busy[r]    = cnt[r] != 2'd0;
      iss_full   = iss_full | (iss_hit[r] && cnt[r] == 2'd3);
    end
  end
  // read ports, hazard detection and the gated claim
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_hold = '0;
    for (int i = 0; i < NRP; i++)
      for (int r = 0; r < NREGS; r++)
        if (bus.rd_addr[i*AW +: AW] == AW'(r)) begin
          rd_busy[i] = busy[r];
`ifdef REGFILE_BYPASS_EN
          rd_data[i*XLEN +: XLEN] = wr_hit[r] ? bus.wr_data : regs[r];
          rd_hold[i] = busy[r] && !(wr_hit[r] && cnt[r] == 2'd1);
`else
          rd_data[i*XLEN +: XLEN] = regs[r];
          rd_hold[i] = busy[r];
`endif
        end
    stall = |(bus.rd_valid & rd_hold) | iss_full;
    inc   = stall ? '0 : iss_hit;
  end
  // register array and saturating-at-zero pending counters; flush wins over claims
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    else
      for (int r = 0; r < NREGS; r++) begin
        if (wr_hit[r]) regs[r] <= bus.wr_data;
        cnt[r] <= bus.flush                         ? 2'd0 :
                  (inc[r] && !wr_hit[r])            ? cnt[r] + 2'd1 :
                  (wr_hit[r] && !inc[r] && busy[r]) ? cnt[r] - 2'd1 : cnt[r];
      end
  assign bus.rd_data  = rd_data;
  assign bus.rd_busy  = rd_busy;
  assign bus.stall    = stall;
  assign bus.busy_vec = busy;
  for (genvar k = 0; k < NDBG; k++) assign bus.dbg_data[k*XLEN +: XLEN] = regs[k+1];
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb with directed vectors
module tb_reg_file_sb;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct packed {
    logic [7:0]  id;
    logic [63:0] d1, d0;
    logic        st;
    logic [31:0] bv;
    logic [63:0] x1;
    logic [1:0]  rb;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];
  reg_file_sb_if bus ();
  reg_file_sb dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int id, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", n, id, act, want);
    end
  endtask
  // monitor: compare combinational outputs mid-cycle against the queued expectation
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("rd_data1", int'(e.id), bus.rd_data[127:64], e.d1);
      chk("rd_data0", int'(e.id), bus.rd_data[63:0], e.d0);
      chk("stall", int'(e.id), 64'(bus.stall), 64'(e.st));
      chk("busy_vec", int'(e.id), 64'(bus.busy_vec), 64'(e.bv));
      chk("dbg_x1", int'(e.id), bus.dbg_data[63:0], e.x1);
      chk("rd_busy", int'(e.id), 64'(bus.rd_busy), 64'(e.rb));
    end
  task automatic t(input int id, input logic [1:0] rv, input logic [4:0] a1, input logic [4:0] a0,
                   input logic ie, input logic [4:0] ia, input logic we, input logic [4:0] wa,
                   input logic [63:0] wd, input logic fl, input logic rs,
                   input logic [63:0] e1, input logic [63:0] e0, input logic es,
                   input logic [31:0] ebv, input logic [63:0] ex1, input logic [1:0] erb);
    exp_t e;
    @(posedge clk);
    #1;
    bus.rd_valid = rv;
    bus.rd_addr  = {a1, a0};
    bus.iss_en   = ie;
    bus.iss_addr = ia;
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
    bus.flush    = fl;
    reset        = rs;
    e.id = id[7:0]; e.d1 = e1; e.d0 = e0; e.st = es; e.bv = ebv; e.x1 = ex1; e.rb = erb;
    q.push_back(e);
  endtask
  initial begin
    bus.rd_valid = '0; bus.rd_addr = '0; bus.iss_en = 1'b0; bus.iss_addr = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.flush = 1'b0;
    //  id rv a1 a0 ie ia we wa wd fl rs | e1 e0 st bv x1 rb
    t( 1, 0, 0, 1, 0, 0, 1, 1, 10, 0, 0,   0, 0, 0, 0, 0, 0);
    t( 2, 0, 0, 1, 0, 0, 1, 1, 10, 0, 0,   0, 0, 0, 0, 0, 0);
    t( 3, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0);
    t( 4, 0, 0, 0, 0, 0, 1, 1, 10, 0, 1,   0, 0, 0, 0, 0, 0);
    t( 5, 0, 2, 1, 0, 0, 1, 2, 20, 0, 1,   BYP ? 64'd20 : 64'd0, 10, 0, 0, 10, 0);
    t( 6, 0, 2, 1, 0, 0, 1, 0, 99, 0, 1,   20, 10, 0, 0, 10, 0);
    t( 7, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1,   0, 0, 0, 0, 10, 0);
    t( 8, 0, 2, 1, 1,10, 0, 0,  0, 0, 1,   20, 10, 0, 0, 10, 0);
    t( 9, 1, 2,10, 0, 0, 0, 0,  0, 0, 1,   20, 0, 1, 32'h400, 10, 1);
    t(10, 1, 2,10, 0, 0, 0, 0,  0, 0, 1,   20, 0, 1, 32'h400, 10, 1);
    t(11, 1, 2,10, 0, 0, 1,10,  5, 0, 1,   20, BYP ? 64'd5 : 64'd0, !BYP, 32'h400, 10, 1);
    t(12, 1, 2,10, 0, 0, 0, 0,  0, 0, 1,   20, 5, 0, 0, 10, 0);
    t(13, 0, 2, 5, 1, 5, 0, 0,  0, 0, 1,   20, 0, 0, 0, 10, 0);
    t(14, 0, 2, 5, 1, 5, 0, 0,  0, 0, 1,   20, 0, 0, 32'h20, 10, 1);
    t(15, 0, 2, 5, 1, 5, 0, 0,  0, 0, 1,   20, 0, 0, 32'h20, 10, 1);
    t(16, 0, 2, 5, 1, 5, 0, 0,  0, 0, 1,   20, 0, 1, 32'h20, 10, 1);
    t(17, 0, 2, 5, 0, 0, 1, 5, 55, 0, 1,   20, BYP ? 64'd55 : 64'd0, 0, 32'h20, 10, 1);
    t(18, 0, 2, 5, 0, 0, 1, 5, 56, 0, 1,   20, BYP ? 64'd56 : 64'd55, 0, 32'h20, 10, 1);
    t(19, 0, 2, 5, 0, 0, 1, 5, 57, 0, 1,   20, BYP ? 64'd57 : 64'd56, 0, 32'h20, 10, 1);
    t(20, 0, 2, 5, 0, 0, 0, 0,  0, 0, 1,   20, 57, 0, 0, 10, 0);
    t(21, 0, 2, 1, 1,17, 0, 0,  0, 0, 1,   20, 10, 0, 0, 10, 0);
    t(22, 0, 2, 1, 1,18, 0, 0,  0, 1, 1,   20, 10, 0, 32'h20000, 10, 0);
    t(23, 0, 2, 1, 0, 0, 0, 0,  0, 0, 1,   20, 10, 0, 0, 10, 0);
    t(24, 0, 2, 1, 0, 0, 1,17,  0, 0, 1,   20, 10, 0, 0, 10, 0);
    t(25, 0, 2, 1, 1,17, 0, 0,  0, 0, 1,   20, 10, 0, 0, 10, 0);
    t(26, 0, 2, 1, 0, 0, 0, 0,  0, 0, 1,   20, 10, 0, 32'h20000, 10, 0);
    t(27, 0, 2, 1, 0, 0, 1,17,  0, 0, 1,   20, 10, 0, 32'h20000, 10, 0);
    t(28, 0, 2, 1, 0, 0, 0, 0,  0, 0, 1,   20, 10, 0, 0, 10, 0);
    t(29, 0, 2, 7, 1, 7, 0, 0,  0, 0, 1,   20, 0, 0, 0, 10, 0);
    t(30, 0, 2, 7, 1, 7, 1, 7, 77, 0, 1,   20, BYP ? 64'd77 : 64'd0, 0, 32'h80, 10, 1);
    t(31, 0, 2, 7, 0, 0, 0, 0,  0, 0, 1,   20, 77, 0, 32'h80, 10, 1);
    t(32, 0, 2, 7, 0, 0, 1, 7, 78, 0, 1,   20, BYP ? 64'd78 : 64'd77, 0, 32'h80, 10, 1);
    t(33, 0, 2, 7, 0, 0, 0, 0,  0, 0, 1,   20, 78, 0, 0, 10, 0);
    t(34, 0, 2, 1, 1, 0, 0, 0,  0, 0, 1,   20, 10, 0, 0, 10, 0);
    t(35, 0, 2, 1, 1, 3, 0, 0,  0, 0, 1,   20, 10, 0, 0, 10, 0);
    t(36, 0, 2, 1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the pipeline's 2-read/1-write integer register file.
- Generalised in width (XLEN), depth (NREGS) and read-port count (NRP).
- Adds a per-register pending-write scoreboard: decode claims a destination at issue; writeback releases it.
- The block drives the decode-stage stall directly, so the RAW/load-use check moves out of the hazard unit. It also exports debug taps of the low registers for the top-level element outputs.

Parameters:
- XLEN, 64, register data width in bits.
- NREGS, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, address width; must satisfy 2**AW >= NREGS.
- NRP, 2, number of combinational read ports.
- NDBG, 8, number of debug taps; tap k shows register k+1, with NDBG <= NREGS-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- rd_valid  input  NRP  port i's source operand is actually used this cycle.
- rd_addr  input  NRP*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  output  NRP*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rd_busy  output  NRP  port i's register has a pending write.
- iss_en  input  1  decode issues an instruction that writes iss_addr.
- iss_addr  input  AW  destination being claimed.
- wr_en  input  1  writeback strobe.
- wr_addr  input  AW  writeback destination.
- wr_data  input  XLEN  writeback data.
- flush  input  1  branch flush; discards all pending claims.
- stall  output  1  decode must hold this cycle.
- busy_vec  output  NREGS  bit r = pending-write count of register r is nonzero.
- dbg_data  output  NDBG*XLEN  registers 1..NDBG, flattened.

Behaviour:
Reset and register 0:
- While reset=0 (asynchronous): all registers are 0 and all pending counters are 0.
- Consequently rd_data=0, rd_busy=0, stall=0, busy_vec=0, dbg_data=0.
- Register 0 always reads 0. Writes to it are ignored, and it is never claimed (iss_addr=0 does not change any counter).
- Addresses >= NREGS read 0, are never busy, and writes to them are ignored.

Register writes and reads:
- Write: on a posedge with wr_en=1 and wr_addr valid and nonzero, register[wr_addr] <= wr_data.
- Reads are combinational from the register array, with zero latency. The value returned during a same-cycle write depends on the optional feature below.

Scoreboard:
- Each register r>0 has a 2-bit pending counter cnt[r], range 0..3, updated on posedge.
- Increment: iss_en=1 and stall=0 and addr=r.
- Decrement: wr_en=1 and addr=r.
- Increment and decrement of the same r in the same cycle: counter unchanged.
- Decrement at 0: counter holds at 0; the register write still occurs.
- flush=1 on a posedge: all counters become 0. flush has priority over a same-cycle increment. A same-cycle write still updates the register.
- busy[r] = (cnt[r] != 0). rd_busy[i] = busy[rd_addr[i]].

Stall:
- stall = OR over i of (rd_valid[i] & rd_busy[i]), OR (iss_en & cnt[iss_addr]==3).
- With the optional feature, a port whose address matches a same-cycle wr_en write with cnt==1 is not counted as busy, because its data is bypassed.
- A stalled issue does not increment its counter.

Mid-operation reset: asserting reset at any time clears all state immediately. There is no dependence on the clock.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: when wr_en=1, wr_addr!=0 and rd_addr[i]==wr_addr, rd_data[i]=wr_data in the same cycle (write-through). The stall relaxation described above also applies.
- Undefined: rd_data returns the old register value until the next cycle, and stall is computed from busy only.

Test Plan:
1. Hold reset=0 during a wr_en write of x1=10 -> register stays 0; rd_data=0, stall=0 and dbg_data=0 throughout reset.
2. Write x1=10 then x2=20 on consecutive cycles; read rd_addr={2,1} -> rd_data={20,10}. Write x0=99 -> x0 reads 0 and busy_vec[0]=0.
3. Issue x10 (load), then rd_valid[0]=1 with rd_addr[0]=10 -> stall=1 until the wr_en x10=5 cycle.
   - With REGFILE_BYPASS_EN: stall=0 in the writeback cycle and rd_data[0]=5.
   - Without: stall=0 one cycle later, reading 5.
4. Issue x5 three times, then a fourth issue of x5 -> stall=1 and cnt stays 3. Three writebacks of x5 -> busy_vec[5] clears only after the third.
5. Issue x17, then flush=1 in the same cycle as an issue of x18 -> busy_vec=0 afterwards. A later wr_en x17=0 leaves cnt[17]=0.
6. Same-cycle iss_en and wr_en to x7 with cnt[7]=1 -> cnt[7] stays 1 and register x7 holds wr_data.
